// File: rtl/d_latch.sv
`default_nettype none
// ============================================================================
// Module   : d_latch
// Brief    : Clocked D-latch model with load-valid flag and change pulse.
// Revision : 1.0 - initial release
// ============================================================================
module d_latch #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             changed
);

    logic [WIDTH-1:0] r_q;
    logic             r_valid;
    logic             r_changed;
    logic             w_differs;

    assign w_differs = (d != r_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q       <= '0;
            r_valid   <= 1'b0;
            r_changed <= 1'b0;
        end else begin
            // A pulse only for loads that actually alter the stored value.
            r_changed <= en & w_differs;
            if (en) begin
                r_q     <= d;
                r_valid <= 1'b1;
            end
        end
    end

    assign q       = r_q;
    assign q_valid = r_valid;
    assign changed = r_changed;

endmodule
`default_nettype wire

// File: tb/tb_d_latch.sv
`default_nettype none
// ============================================================================
// Module   : tb_d_latch
// Brief    : Self-checking bench for d_latch: directed and random stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_d_latch;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en  = 1'b0;
    logic [W-1:0] d   = '0;
    logic [W-1:0] q;
    logic         q_valid;
    logic         changed;

    int checks = 0;
    int passed = 0;

    // Reference state: what was last stored, whether anything has been stored,
    // and whether the most recent edge replaced the stored value with a new one.
    logic [W-1:0] m_stored  = '0;
    logic         m_loaded  = 1'b0;
    logic         m_pulse   = 1'b0;
    logic         m_known   = 1'b0;

    d_latch #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .d       (d),
        .en      (en),
        .q       (q),
        .q_valid (q_valid),
        .changed (changed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model update and per-cycle comparison.
    initial begin
        logic         s_rst, s_en;
        logic [W-1:0] s_d, prev;
        forever begin
            @(posedge clk);
            s_rst = rst; s_en = en; s_d = d;
            if (s_rst) begin
                m_stored = '0; m_loaded = 1'b0; m_pulse = 1'b0; m_known = 1'b1;
            end else if (m_known) begin
                prev     = m_stored;
                m_stored = s_en ? s_d : prev;
                m_loaded = m_loaded | s_en;
                m_pulse  = s_en && (s_d != prev);
            end
            #1;
            if (m_known) begin
                chk("model_q", q, m_stored);
                chk("model_q_valid", {{(W-1){1'b0}}, q_valid}, {{(W-1){1'b0}}, m_loaded});
                chk("model_changed", {{(W-1){1'b0}}, changed}, {{(W-1){1'b0}}, m_pulse});
            end
        end
    end

    task automatic step(input logic r, input logic e, input logic [W-1:0] v);
        @(negedge clk);
        rst = r; en = e; d = v;
        @(posedge clk);
        #2;
    endtask

    task automatic expect3(input string tag, input logic [W-1:0] eq, input logic ev, input logic ec);
        chk({tag, "_q"}, q, eq);
        chk({tag, "_valid"}, {{(W-1){1'b0}}, q_valid}, {{(W-1){1'b0}}, ev});
        chk({tag, "_changed"}, {{(W-1){1'b0}}, changed}, {{(W-1){1'b0}}, ec});
    endtask

    initial begin
        step(1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b0, 4'h0);
        expect3("reset", 4'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b0, 4'h0);
        expect3("idle", 4'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'h1);
        expect3("first_load", 4'h1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 4'h1);
        expect3("pulse_end", 4'h1, 1'b1, 1'b0);
        repeat (9) step(1'b0, 1'b0, 4'h1);
        expect3("hold_d1", 4'h1, 1'b1, 1'b0);
        repeat (10) step(1'b0, 1'b0, 4'h0);
        expect3("hold_d0", 4'h1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 4'h0);
        expect3("tog0", 4'h0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 4'h1);
        expect3("tog1", 4'h1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 4'h0);
        expect3("tog2", 4'h0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 4'h0);
        expect3("equal_load", 4'h0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 4'hA);
        expect3("wide_load", 4'hA, 1'b1, 1'b1);
        step(1'b0, 1'b1, 4'h1);
        step(1'b1, 1'b1, 4'h1);
        expect3("rst_over_en", 4'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'h0);
        expect3("post_rst_equal", 4'h0, 1'b1, 1'b0);

        // Narrow data range so equal-value loads occur often.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 2) != 0),
                 W'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 1)));
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
